// File: rtl/slot_pkg.sv
// slot_pkg: shared state encoding and default game constants for the slot controller
package slot_pkg;
  typedef enum logic [2:0] {IDLE, SPIN0, SPIN1, SPIN2, EVAL} state_t;
  localparam int DEF_NBITS_COUNT   = 4;
  localparam int DEF_NBITS_CRED    = 8;
  localparam int DEF_INIT_CREDITS  = 10;
  localparam int DEF_BET           = 1;
  localparam int DEF_PAIR_PRIZE    = 2;
  localparam int DEF_JACKPOT_PRIZE = 10;
  localparam int DEF_COIN_VALUE    = 5;
  localparam int DEF_AUTO_STOP     = 8;
endpackage

// File: rtl/slot_game_ctrl_if.sv
// slot_game_ctrl_if: player switches, reel digits in; locks, balance and flags out
// master: drives start/stop/coin/reel1..3, reads trava/credits/win/jackpot/busy/no_credit
// slave : the game controller side
interface slot_game_ctrl_if import slot_pkg::*; #(
  parameter int NBITS_COUNT = DEF_NBITS_COUNT,
  parameter int NBITS_CRED  = DEF_NBITS_CRED
);
  logic                   start, stop, coin;
  logic [NBITS_COUNT-1:0] reel1, reel2, reel3;
  logic [2:0]             trava;
  logic [NBITS_CRED-1:0]  credits;
  logic                   win, jackpot, busy, no_credit;
  modport master (output start, stop, coin, reel1, reel2, reel3,
                  input  trava, credits, win, jackpot, busy, no_credit);
  modport slave  (input  start, stop, coin, reel1, reel2, reel3,
                  output trava, credits, win, jackpot, busy, no_credit);
endinterface

// File: rtl/slot_game_ctrl_rise_detect.sv
// rise_detect: rising-edge detector for a level switch
// ports: clk_2, reset (sync, active-low), d (switch level), rise (one-cycle event)
// prev resets to 1 so a switch held high through reset yields no event
module rise_detect (
  input  logic clk_2,
  input  logic reset,
  input  logic d,
  output logic rise
);
  logic prev_q, prev_d;
  always_comb prev_d = d;
  always_ff @(posedge clk_2) prev_q <= !reset ? 1'b1 : prev_d;
  assign rise = d & ~prev_q;
endmodule

// File: rtl/slot_game_ctrl.sv
// slot_game_ctrl: three-reel spin sequencer, scorer and saturating credit keeper
// ports: clk_2, reset (sync, active-low), bus (slave): switches and reel digits in,
// per-reel locks, credit balance, win/jackpot/busy flags and no_credit out
module slot_game_ctrl import slot_pkg::*; #(
  parameter int NBITS_COUNT   = DEF_NBITS_COUNT,
  parameter int NBITS_CRED    = DEF_NBITS_CRED,
  parameter int INIT_CREDITS  = DEF_INIT_CREDITS,
  parameter int BET           = DEF_BET,
  parameter int PAIR_PRIZE    = DEF_PAIR_PRIZE,
  parameter int JACKPOT_PRIZE = DEF_JACKPOT_PRIZE,
  parameter int COIN_VALUE    = DEF_COIN_VALUE,
  parameter int AUTO_STOP     = DEF_AUTO_STOP
) (
  input logic        clk_2,
  input logic        reset,
  slot_game_ctrl_if.slave bus
);
  localparam int TW = $clog2(AUTO_STOP) + 1;
  localparam int CW = NBITS_CRED + 2;
  localparam logic [CW-1:0] MAX_CRED = CW'((1 << NBITS_CRED) - 1);
  state_t                state_q, state_d;
  logic [2:0]            trava_q, trava_d;
  logic [NBITS_CRED-1:0] credits_q, credits_d;
  logic [TW-1:0]         timer_q, timer_d;
  logic                  win_q, win_d, jackpot_q, jackpot_d, busy_q, busy_d;
  logic                  start_r, stop_r, coin_r, no_credit, acc_start, adv, three, pair;
  logic [CW-1:0]         prize, sum;
  rise_detect u_start (.clk_2(clk_2), .reset(reset), .d(bus.start), .rise(start_r));
  rise_detect u_stop  (.clk_2(clk_2), .reset(reset), .d(bus.stop),  .rise(stop_r));
  rise_detect u_coin  (.clk_2(clk_2), .reset(reset), .d(bus.coin),  .rise(coin_r));
  assign no_credit = credits_q < NBITS_CRED'(BET);
  always_comb begin
    three     = (bus.reel1 == bus.reel2) && (bus.reel2 == bus.reel3);
    pair      = (bus.reel1 == bus.reel2) || (bus.reel1 == bus.reel3) || (bus.reel2 == bus.reel3);
    acc_start = (state_q == IDLE) && start_r && !no_credit;
    adv       = stop_r || (timer_q == TW'(AUTO_STOP - 1));
    prize     = (state_q != EVAL) ? '0 : three ? CW'(JACKPOT_PRIZE) : pair ? CW'(PAIR_PRIZE) : '0;
    // at most +coin+prize on top of a full balance, and the bet is only taken when affordable
    sum       = CW'(credits_q) + (coin_r ? CW'(COIN_VALUE) : '0) + prize - (acc_start ? CW'(BET) : '0);
    credits_d = (sum > MAX_CRED) ? MAX_CRED[NBITS_CRED-1:0] : sum[NBITS_CRED-1:0];
    state_d   = state_q;
    trava_d   = trava_q;
    win_d     = win_q;
    jackpot_d = jackpot_q;
    timer_d   = timer_q + TW'(1);
    case (state_q)
      IDLE: begin
        timer_d = '0;
        if (acc_start) begin
          state_d   = SPIN0;
          trava_d   = 3'b000;
          win_d     = 1'b0;
          jackpot_d = 1'b0;
        end
      end
      SPIN0: if (adv) begin state_d = SPIN1; trava_d = 3'b001; timer_d = '0; end
      SPIN1: if (adv) begin state_d = SPIN2; trava_d = 3'b011; timer_d = '0; end
      SPIN2: if (adv) begin state_d = EVAL;  trava_d = 3'b111; timer_d = '0; end
      default: begin
        state_d   = IDLE;
        timer_d   = '0;
        win_d     = pair;
        jackpot_d = three;
      end
    endcase
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge clk_2) begin
    if (!reset) begin
      state_q   <= IDLE;
      trava_q   <= 3'b111;
      credits_q <= NBITS_CRED'(INIT_CREDITS);
      timer_q   <= '0;
      win_q     <= 1'b0;
      jackpot_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      trava_q   <= trava_d;
      credits_q <= credits_d;
      timer_q   <= timer_d;
      win_q     <= win_d;
      jackpot_q <= jackpot_d;
      busy_q    <= busy_d;
    end
  end
  assign bus.trava     = trava_q;
  assign bus.credits   = credits_q;
  assign bus.win       = win_q;
  assign bus.jackpot   = jackpot_q;
  assign bus.busy      = busy_q;
  assign bus.no_credit = no_credit;
endmodule

// File: tb/tb_slot_game_ctrl.sv
// tb_slot_game_ctrl: directed self-checking bench for slot_game_ctrl
module tb_slot_game_ctrl;
  logic clk_2 = 1'b0;
  logic reset = 1'b0;
  int   errors = 0;
  int   checks = 0;
  int   cred;
  typedef struct {
    logic [3:0] r1, r2, r3;
    int         prize;
    logic       w, j;
  } vec_t;
  vec_t vecs [7];
  slot_game_ctrl_if bus ();
  slot_game_ctrl dut (.clk_2(clk_2), .reset(reset), .bus(bus));
  always #5 clk_2 = ~clk_2;
  task automatic tick;
    @(posedge clk_2);
    #1;
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic do_reset;
    reset = 1'b0;
    bus.start = 1'b0;
    bus.stop = 1'b0;
    bus.coin = 1'b0;
    tick;
    tick;
    reset = 1'b1;
    tick;
    cred = 10;
  endtask
  task automatic add_coin;
    bus.coin = 1'b1;
    tick;
    bus.coin = 1'b0;
    tick;
    cred = (cred + 5 > 255) ? 255 : cred + 5;
  endtask
  task automatic spin(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                      input int prize, input logic w, input logic j, input logic with_coin,
                      input string name);
    int n;
    bus.reel1 = a;
    bus.reel2 = b;
    bus.reel3 = c;
    bus.coin = with_coin;
    bus.start = 1'b1;
    tick;
    bus.start = 1'b0;
    bus.coin = 1'b0;
    cred = cred - 1 + (with_coin ? 5 : 0);
    chk({name, " accept credits"}, bus.credits, cred);
    chk({name, " accept busy"}, bus.busy, 1);
    chk({name, " accept trava"}, bus.trava, 3'b000);
    chk({name, " accept win"}, bus.win, 0);
    n = 0;
    while (bus.busy === 1'b1 && n < 100) begin
      tick;
      n++;
      if (n == 8)  chk({name, " trava@8"}, bus.trava, 3'b001);
      if (n == 16) chk({name, " trava@16"}, bus.trava, 3'b011);
      if (n == 24) chk({name, " trava@24"}, bus.trava, 3'b111);
    end
    chk({name, " spin length"}, n, 25);
    cred = (cred + prize > 255) ? 255 : cred + prize;
    chk({name, " final credits"}, bus.credits, cred);
    chk({name, " win"}, bus.win, w);
    chk({name, " jackpot"}, bus.jackpot, j);
    chk({name, " idle trava"}, bus.trava, 3'b111);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    vecs[0] = '{4'd3, 4'd3, 4'd3, 10, 1'b1, 1'b1};
    vecs[1] = '{4'd2, 4'd2, 4'd5, 2, 1'b1, 1'b0};
    vecs[2] = '{4'd1, 4'd2, 4'd3, 0, 1'b0, 1'b0};
    vecs[3] = '{4'd5, 4'd2, 4'd5, 2, 1'b1, 1'b0};
    vecs[4] = '{4'd5, 4'd7, 4'd7, 2, 1'b1, 1'b0};
    vecs[5] = '{4'd0, 4'd0, 4'd0, 10, 1'b1, 1'b1};
    vecs[6] = '{4'd15, 4'd14, 4'd13, 0, 1'b0, 1'b0};
    bus.start = 1'b1;
    bus.stop = 1'b0;
    bus.coin = 1'b0;
    bus.reel1 = '0;
    bus.reel2 = '0;
    bus.reel3 = '0;
    tick;
    tick;
    reset = 1'b1;
    repeat (5) tick;
    chk("held start busy", bus.busy, 0);
    chk("held start credits", bus.credits, 10);
    chk("held start trava", bus.trava, 3'b111);
    chk("held start win", bus.win, 0);
    chk("held start no_credit", bus.no_credit, 0);
    for (int i = 0; i < 7; i++) begin
      do_reset;
      spin(vecs[i].r1, vecs[i].r2, vecs[i].r3, vecs[i].prize, vecs[i].w, vecs[i].j, 1'b0,
           $sformatf("vec%0d", i));
    end
    do_reset;
    bus.reel1 = 4'd1;
    bus.reel2 = 4'd2;
    bus.reel3 = 4'd3;
    bus.start = 1'b1;
    tick;
    bus.start = 1'b0;
    repeat (7) tick;
    chk("coincide pre trava", bus.trava, 3'b000);
    bus.stop = 1'b1;
    tick;
    chk("coincide lock1", bus.trava, 3'b001);
    repeat (7) tick;
    chk("coincide hold", bus.trava, 3'b001);
    tick;
    chk("coincide lock2", bus.trava, 3'b011);
    bus.stop = 1'b0;
    do_reset;
    bus.start = 1'b1;
    tick;
    bus.start = 1'b0;
    tick;
    tick;
    bus.stop = 1'b1;
    tick;
    chk("stop lock1", bus.trava, 3'b001);
    bus.stop = 1'b0;
    tick;
    bus.stop = 1'b1;
    tick;
    chk("stop lock2", bus.trava, 3'b011);
    bus.stop = 1'b0;
    tick;
    bus.stop = 1'b1;
    tick;
    chk("stop lock3", bus.trava, 3'b111);
    chk("stop eval busy", bus.busy, 1);
    tick;
    bus.stop = 1'b0;
    chk("stop done busy", bus.busy, 0);
    chk("stop done credits", bus.credits, 9);
    do_reset;
    for (int i = 0; i < 10; i++) spin(4'd1, 4'd2, 4'd3, 0, 1'b0, 1'b0, 1'b0, $sformatf("drain%0d", i));
    chk("broke no_credit", bus.no_credit, 1);
    bus.start = 1'b1;
    tick;
    bus.start = 1'b0;
    chk("broke start busy", bus.busy, 0);
    chk("broke start credits", bus.credits, 0);
    chk("broke start trava", bus.trava, 3'b111);
    tick;
    add_coin;
    chk("coin credits", bus.credits, 5);
    chk("coin no_credit", bus.no_credit, 0);
    spin(4'd1, 4'd2, 4'd3, 0, 1'b0, 1'b0, 1'b0, "after coin");
    do_reset;
    spin(4'd2, 4'd2, 4'd5, 2, 1'b1, 1'b0, 1'b1, "coin+start");
    spin(4'd2, 4'd2, 4'd5, 2, 1'b1, 1'b0, 1'b0, "pair a");
    spin(4'd2, 4'd2, 4'd5, 2, 1'b1, 1'b0, 1'b0, "pair b");
    repeat (47) add_coin;
    chk("credits 253", bus.credits, 253);
    add_coin;
    chk("saturate 255", bus.credits, 255);
    add_coin;
    chk("saturate hold", bus.credits, 255);
    do_reset;
    spin(4'd3, 4'd3, 4'd3, 10, 1'b1, 1'b1, 1'b0, "pre reset jackpot");
    bus.start = 1'b1;
    tick;
    bus.start = 1'b0;
    repeat (10) tick;
    chk("mid spin trava", bus.trava, 3'b001);
    reset = 1'b0;
    tick;
    chk("reset busy", bus.busy, 0);
    chk("reset trava", bus.trava, 3'b111);
    chk("reset credits", bus.credits, 10);
    chk("reset win", bus.win, 0);
    chk("reset jackpot", bus.jackpot, 0);
    reset = 1'b1;
    tick;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
